// File: rtl/adder_nbits_seq.sv
// -----------------------------------------------------------------------------
// adder_nbits_seq
//
// Multi-cycle ripple adder. An accepted start captures the operands. The
// module then adds CHUNK bits per clock, least significant chunk first, and
// carries between chunks through a stored carry bit. After N = WIDTH/CHUNK
// RUN cycles the result registers load, and done pulses for one cycle.
//
// Optional feature (macro ADDER_SUB_EN):
//   When ADDER_SUB_EN is defined, the module has an extra input port, sub.
//   With sub=1 the module computes a + ~b + 1 and ignores cin.
//   When the macro is undefined, the sub port does not exist.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   CHUNK  bits added per clock (1..WIDTH, WIDTH divisible by CHUNK)
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   add request, sampled only while idle
//   a, b   in   operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   sub    in   (ADDER_SUB_EN only) subtract select, captured on accepted start
//   busy   out  operation in progress
//   done   out  one-cycle pulse, result registers just updated
//   sum    out  registered (a+b+cin) mod 2^WIDTH
//   cout   out  registered carry out of bit WIDTH-1
//   ovf    out  registered signed overflow
//
// States:
//   state  | meaning
//   S_IDLE | waiting for start; result registers hold the last result
//   S_RUN  | adding one chunk per clock; loads the result on the last chunk
// -----------------------------------------------------------------------------
module adder_nbits_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // The operand registers shift right by one chunk per RUN cycle, so the
  // active chunk is always in the low bits.
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk_out;
  logic             c_into_msb;
  logic             last_chunk;

  logic [WIDTH-1:0] b_capture;
  logic             c_capture;

`ifdef ADDER_SUB_EN
  // Subtract as a + ~b + 1. The inversion and the forced carry happen at
  // capture time, so the datapath only ever adds.
  always_comb begin
    b_capture = sub ? ~b : b;
    c_capture = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_capture = b;
    c_capture = cin;
  end
`endif

  assign a_chunk    = a_q[CHUNK-1:0];
  assign b_chunk    = b_q[CHUNK-1:0];
  assign last_chunk = (cnt_q == CNT_LAST);

  // Ripple of CHUNK full-adder cells fed by the stored carry. The carry into
  // the top cell is kept because, on the last chunk, that is the carry into
  // the MSB of the whole word, which the overflow flag needs.
  always_comb begin
    logic c;
    c          = carry_q;
    c_into_msb = 1'b0;
    s_chunk    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        c_into_msb = c;
      end
      s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c;
      c          = (a_chunk[i] & b_chunk[i]) | (c & (a_chunk[i] ^ b_chunk[i]));
    end
    c_chunk_out = c;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_capture;
          carry_d = c_capture;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d    = a_q >> CHUNK;
        b_d    = b_q >> CHUNK;
        // New chunk bits enter at the top. After N shifts, chunk 0 has
        // reached the bottom and the word is in its natural order.
        psum_d = psum_q >> CHUNK;
        psum_d[WIDTH-1 -: CHUNK] = s_chunk;
        carry_d = c_chunk_out;
        cnt_d   = cnt_q + 1'b1;

        if (last_chunk) begin
          // The final carry goes only to cout. It is never fed back into
          // the chain.
          sum_d   = psum_d;
          cout_d  = c_chunk_out;
          ovf_d   = c_into_msb ^ c_chunk_out;
          done_d  = 1'b1;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_nbits_seq.sv
// Testbench for adder_nbits_seq.
// The driver issues operations and pushes the expected results into a
// scoreboard queue. The monitor runs on the falling edge and compares the
// DUT outputs against that queue.
module tb_adder_nbits_seq;

  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam int N     = WIDTH / CHUNK;
`ifdef ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif

  adder_nbits_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    int               done_at;
  } exp_t;

  exp_t             sbq[$];
  int               checks = 0;
  int               errors = 0;
  int               ec = 0;          // rising edges seen by the driver
  bit               mon_en = 1'b0;
  bit               op_active = 1'b0;
  int               op_done_at = 0;
  logic [WIDTH-1:0] h_sum = '0;      // result the outputs should be holding
  logic             h_cout = 1'b0;
  logic             h_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h edge=%0d", nm, act, exp, ec);
    end
  endtask

  // Reference model: plain wide arithmetic on the operands as given.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv, input int at);
    exp_t             r;
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic [WIDTH:0]   full;
    bb = bv;
    cc = cv;
    if (SUB_EN && sv) begin
      bb = ~bv;
      cc = 1'b1;
    end
    full      = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    r.s       = full[WIDTH-1:0];
    r.co      = full[WIDTH];
    r.ov      = (av[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
    r.done_at = at;
    return r;
  endfunction

  // Drives one clock cycle of inputs and updates the model after the edge.
  task automatic step(input logic rn, input logic st, input logic [WIDTH-1:0] av,
                      input logic [WIDTH-1:0] bv, input logic cv, input logic sv);
    rst_n = rn;
    start = st;
    a     = av;
    b     = bv;
    cin   = cv;
`ifdef ADDER_SUB_EN
    sub   = sv;
`endif
    @(posedge clk);
    #1;
    ec++;
    if (!rn) begin
      sbq.delete();
      op_active = 1'b0;
      h_sum     = '0;
      h_cout    = 1'b0;
      h_ovf     = 1'b0;
    end else if (st && (!op_active || ec > op_done_at)) begin
      op_active  = 1'b1;
      op_done_at = ec + N;
      sbq.push_back(model(av, bv, cv, sv, ec + N));
    end
  endtask

  task automatic idle_rand();
    step(1'b1, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                    input logic cv, input logic sv);
    step(1'b1, 1'b1, av, bv, cv, sv);
    for (int i = 0; i < N + 1; i++) idle_rand();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin : mon
      logic exp_busy;
      logic exp_done;
      exp_t e;
      exp_busy = op_active && (ec < op_done_at);
      exp_done = (sbq.size() > 0) && (sbq[0].done_at == ec);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (sbq.size() > 0 && sbq[0].done_at <= ec) begin
        e      = sbq.pop_front();
        h_sum  = e.s;
        h_cout = e.co;
        h_ovf  = e.ov;
      end
      chk("sum", sum, h_sum);
      chk("cout", cout, h_cout);
      chk("ovf", ovf, h_ovf);
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef ADDER_SUB_EN
    sub   = 1'b0;
`endif
    step(1'b0, 1'b1, '1, '1, 1'b1, 1'b0);
    step(1'b0, 1'b1, '1, '1, 1'b1, 1'b0);
    mon_en = 1'b1;
    idle_rand();

    op(WIDTH'(8'hFF), WIDTH'(8'h01), 1'b0, 1'b0);
    op(WIDTH'(8'h7F), WIDTH'(8'h01), 1'b0, 1'b0);
    op(WIDTH'(8'h80), WIDTH'(8'h80), 1'b0, 1'b0);
    op(WIDTH'(8'h00), WIDTH'(8'h00), 1'b1, 1'b0);

    // start held high with changing operands: ignored while busy,
    // back-to-back accept in each done cycle
    for (int i = 0; i < 3 * (N + 1); i++)
      step(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < N + 1; i++) idle_rand();

    // reset in the second RUN cycle aborts the operation
    step(1'b1, 1'b1, WIDTH'(8'h3C), WIDTH'(8'h5A), 1'b1, 1'b0);
    idle_rand();
    step(1'b0, 1'b1, WIDTH'(8'h11), WIDTH'(8'h22), 1'b0, 1'b0);
    idle_rand();
    op(WIDTH'(8'h12), WIDTH'(8'h34), 1'b1, 1'b0);

    if (SUB_EN) begin
      op(WIDTH'(8'h05), WIDTH'(8'h07), 1'b0, 1'b1);
      op(WIDTH'(8'h07), WIDTH'(8'h05), 1'b1, 1'b1);
    end

    for (int i = 0; i < 1000 * (N + 1); i++) begin
      step(($urandom_range(0, 99) != 0), 1'($urandom), WIDTH'($urandom),
           WIDTH'($urandom), 1'($urandom), SUB_EN ? 1'($urandom) : 1'b0);
    end

    for (int i = 0; i < N + 2; i++) idle_rand();
    chk("drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
